mem_store_datapath: RTL and testbench
=====================================

Name: mem_store_datapath

Overview:
- Memory-stage store/load datapath slice for the 5-stage MIPS32 pipeline.
- Selects forwarded operands with 2:1 muxes (RS/address and RT/store data, WB forwarding).
- Aligns store data to byte lanes and generates byte enables and a misalignment flag.
- Selects load-result vs. RT; registers the outgoing store request for the data bus.

Parameters:
- DW, 32, datapath width (only 32 supported)
- ADDR_MASK_BITS, 3, number of address MSBs forced to 0 on the physical address output

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ao_m  in  32  ALU result in MEM (effective address)
- rt_m  in  32  RT value in MEM
- wb_data  in  32  WB-stage write-back value for forwarding
- fwd_rs  in  1  1 = use wb_data for address operand
- fwd_rt  in  1  1 = use wb_data for store operand
- instr_sb  in  1  store byte
- instr_sh  in  1  store halfword
- instr_sw  in  1  store word
- store_req  in  1  store issued this cycle
- lrm_sel  in  1  1 = load result from mem_rdata
- mem_rdata  in  32  data read from memory
- frs  out  32  forwarded address operand
- frt  out  32  forwarded store operand
- lrm  out  32  load/RT result
- st_wdata  out  32  lane-aligned store data (combinational)
- st_ben  out  4  byte enables (combinational)
- st_misalign  out  1  misaligned SH/SW
- mem_addr  out  32  physical address
- q_valid  out  1  registered request valid
- q_wdata  out  32  registered store data
- q_ben  out  4  registered byte enables
- q_addr  out  32  registered physical address

Behaviour:
- Operand muxes:
  - frs = fwd_rs ? wb_data : ao_m.
  - frt = fwd_rt ? wb_data : rt_m.
  - lrm = lrm_sel ? mem_rdata : frt.
- Addressing: mem_addr = {3'b0, frs[28:0]}; a = frs[1:0].
- Size priority: SB > SH > SW. A store with no size flag asserted is a "none" store.
- Shifter, unused lanes always 0:
  - SB: st_wdata = {24'b0, frt[7:0]} << (8*a).
  - SH (not SB): st_wdata = {16'b0, frt[15:0]} << (16*a[1]).
  - Otherwise: st_wdata = frt.
- Misalignment: st_misalign = (SH & a[0]) | (SW & !SB & !SH & a != 0). SB is never misaligned.
- Byte enables:
  - st_ben = 0 if !store_req or st_misalign.
  - SB: 4'b0001 << a.
  - SH: 4'b0011 << (2*a[1]).
  - SW: 4'b1111.
  - None: 0.
- All of the above are purely combinational with zero latency.
- Registered stage, 1-cycle latency:
  - Each rising clk: q_valid <= store_req & |st_ben.
  - When that value is 1, q_wdata, q_ben and q_addr capture st_wdata, st_ben and mem_addr.
  - Otherwise q_wdata, q_ben and q_addr hold their previous values.
  - A misaligned store produces no q_valid pulse.
- Reset (reset = 0, asynchronous):
  - q_valid, q_wdata, q_ben and q_addr clear to 0 immediately and stay 0 while reset is low.
  - Combinational outputs are unaffected by reset.
  - The first capture happens on the first rising edge after reset deasserts.
- Back-to-back stores capture every cycle; no stall or backpressure.

Test Plan:
- Forwarding, mux outputs:
  - Stimulus: ao_m=0x1000_0004, rt_m=0xAABBCCDD, wb_data=0x0000_0008, fwd_rs=1, fwd_rt=0.
  - Required: frs=0x8, frt=0xAABBCCDD, mem_addr=0x8.
  - Then lrm_sel=1 with mem_rdata=0x1234_5678 -> lrm=0x12345678.
- SB, all lanes: frt=0xAABBCCDD, a=0,1,2,3.
  - st_wdata = 0xDD, 0xDD00, 0xDD0000, 0xDD000000.
  - st_ben = 1, 2, 4, 8.
  - st_misalign = 0 for all.
- SH:
  - a=2 -> st_wdata=0xCCDD0000, st_ben=0xC.
  - a=1 -> st_misalign=1, st_ben=0, and no q_valid pulse next cycle.
- SW:
  - frs=0x2000_0000, frt=0x11223344 -> mem_addr=0x0, st_ben=0xF, st_wdata=0x11223344.
  - Next edge: q_valid=1, q_wdata=0x11223344, q_ben=0xF, q_addr=0x0.
  - frs=0x...2 -> st_misalign=1.
- Reset:
  - Capture SW 0xDEADBEEF, then pull reset low mid-cycle -> all q_* outputs 0 before the next edge.
  - Hold reset low with store_req=1 -> no capture.
  - Release reset -> capture on the next edge.
- Priority and idle:
  - instr_sb=instr_sh=1, a=1 -> treated as SB: st_ben=2, no misalign.
  - store_req=0 -> st_ben=0, q_valid=0, q_wdata holds its prior value.

Source files
------------

// File: rtl/mem_store_datapath.sv
// MEM-stage store/load datapath slice: operand forwarding, store lane alignment,
// byte-enable and misalignment generation, and a registered outgoing store request.
module mem_store_datapath #(
   parameter int DW             = 32,
   parameter int ADDR_MASK_BITS = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] ao_m,
   input  logic [DW-1:0] rt_m,
   input  logic [DW-1:0] wb_data,
   input  logic          fwd_rs,
   input  logic          fwd_rt,
   input  logic          instr_sb,
   input  logic          instr_sh,
   input  logic          instr_sw,
   input  logic          store_req,
   input  logic          lrm_sel,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] frs,
   output logic [DW-1:0] frt,
   output logic [DW-1:0] lrm,
   output logic [DW-1:0] st_wdata,
   output logic [3:0]    st_ben,
   output logic          st_misalign,
   output logic [DW-1:0] mem_addr,
   output logic          q_valid,
   output logic [DW-1:0] q_wdata,
   output logic [3:0]    q_ben,
   output logic [DW-1:0] q_addr
);

   logic [1:0]    addr_lo;
   logic [3:0]    lane_ben;
   logic          q_valid_d, q_valid_q;
   logic [DW-1:0] q_wdata_d, q_wdata_q;
   logic [3:0]    q_ben_d, q_ben_q;
   logic [DW-1:0] q_addr_d, q_addr_q;

   always_comb begin
      frs      = fwd_rs ? wb_data : ao_m;
      frt      = fwd_rt ? wb_data : rt_m;
      lrm      = lrm_sel ? mem_rdata : frt;
      mem_addr = {{ADDR_MASK_BITS{1'b0}}, frs[DW-ADDR_MASK_BITS-1:0]};
      addr_lo  = frs[1:0];
   end

   // Size flags are priority-encoded SB > SH > SW; with none set the word passes through unshifted.
   always_comb begin
      st_wdata    = frt;
      lane_ben    = 4'b0000;
      st_misalign = 1'b0;
      if (instr_sb) begin
         st_wdata = {{(DW-8){1'b0}}, frt[7:0]} << {addr_lo, 3'b000};
         lane_ben = 4'b0001 << addr_lo;
      end else if (instr_sh) begin
         st_wdata    = {{(DW-16){1'b0}}, frt[15:0]} << {addr_lo[1], 4'b0000};
         lane_ben    = 4'b0011 << {addr_lo[1], 1'b0};
         st_misalign = addr_lo[0];
      end else if (instr_sw) begin
         lane_ben    = 4'b1111;
         st_misalign = |addr_lo;
      end
      st_ben = (store_req && !st_misalign) ? lane_ben : 4'b0000;
   end

   // Request register: captures only when a store actually enables a lane, otherwise holds.
   always_comb begin
      q_valid_d = store_req & (|st_ben);
      q_wdata_d = q_valid_d ? st_wdata : q_wdata_q;
      q_ben_d   = q_valid_d ? st_ben   : q_ben_q;
      q_addr_d  = q_valid_d ? mem_addr : q_addr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_valid_q <= 1'b0;
         q_wdata_q <= '0;
         q_ben_q   <= 4'b0000;
         q_addr_q  <= '0;
      end else begin
         q_valid_q <= q_valid_d;
         q_wdata_q <= q_wdata_d;
         q_ben_q   <= q_ben_d;
         q_addr_q  <= q_addr_d;
      end
   end

   assign q_valid = q_valid_q;
   assign q_wdata = q_wdata_q;
   assign q_ben   = q_ben_q;
   assign q_addr  = q_addr_q;

endmodule

// File: tb/tb_mem_store_datapath.sv
// Scoreboard bench for mem_store_datapath: directed cases plus randomized stores
// checked against a lane-by-lane behavioural model.
module tb_mem_store_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ao_m, rt_m, wb_data, mem_rdata;
   logic        fwd_rs, fwd_rt, instr_sb, instr_sh, instr_sw, store_req, lrm_sel;
   logic [31:0] frs, frt, lrm, st_wdata, mem_addr, q_wdata, q_addr;
   logic [3:0]  st_ben, q_ben;
   logic        st_misalign, q_valid;

   typedef struct {
      logic [31:0] ao, rt, wb, rdata;
      logic        frs_sel, frt_sel, sb, sh, sw, req, lsel, rst_n;
   } stim_t;

   typedef struct {
      logic [31:0] wdata;
      logic [3:0]  ben;
      logic [31:0] addr;
   } cap_t;

   cap_t  sb_q[$];
   cap_t  held;
   logic  exp_v;
   int    n_cmp = 0;
   int    n_bad = 0;

   mem_store_datapath #(.DW(32), .ADDR_MASK_BITS(3)) dut (
      .clk(clk), .reset(reset), .ao_m(ao_m), .rt_m(rt_m), .wb_data(wb_data),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .instr_sb(instr_sb), .instr_sh(instr_sh),
      .instr_sw(instr_sw), .store_req(store_req), .lrm_sel(lrm_sel),
      .mem_rdata(mem_rdata), .frs(frs), .frt(frt), .lrm(lrm), .st_wdata(st_wdata),
      .st_ben(st_ben), .st_misalign(st_misalign), .mem_addr(mem_addr),
      .q_valid(q_valid), .q_wdata(q_wdata), .q_ben(q_ben), .q_addr(q_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Each byte lane is filled independently from the size and the low address bits.
   function automatic void model(input logic [31:0] a_frs, input logic [31:0] a_frt,
                                 input logic sb, input logic sh, input logic sw, input logic req,
                                 output logic [31:0] wd, output logic [3:0] be, output logic mis);
      int         a;
      logic [3:0] lanes;
      a     = int'(a_frs[1:0]);
      wd    = '0;
      lanes = '0;
      for (int i = 0; i < 4; i++) begin
         if (sb) begin
            if (i == a) begin wd[8*i +: 8] = a_frt[7:0]; lanes[i] = 1'b1; end
         end else if (sh) begin
            if (i / 2 == a / 2) begin wd[8*i +: 8] = a_frt[8*(i%2) +: 8]; lanes[i] = 1'b1; end
         end else if (sw) begin
            wd[8*i +: 8] = a_frt[8*i +: 8]; lanes[i] = 1'b1;
         end else begin
            wd[8*i +: 8] = a_frt[8*i +: 8];
         end
      end
      mis = !sb && ((sh && (a % 2 == 1)) || (!sh && sw && a != 0));
      be  = (req && !mis) ? lanes : 4'b0000;
   endfunction

   // Monitor: pops one expected capture for every q_valid the DUT presents.
   initial begin
      cap_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && q_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_q_valid: got q_valid=1, expected no request at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               chk("q_wdata", q_wdata, e.wdata);
               chk("q_ben",   {28'b0, q_ben}, {28'b0, e.ben});
               chk("q_addr",  q_addr, e.addr);
            end
         end
      end
   end

   task automatic apply(input stim_t s);
      logic [31:0] efrs, efrt, ewd, eaddr;
      logic [3:0]  ebe;
      logic        emis, nv;
      @(negedge clk);
      #1;
      chk("q_valid", {31'b0, q_valid}, {31'b0, exp_v});
      if (!exp_v) begin
         chk("q_wdata_hold", q_wdata, held.wdata);
         chk("q_ben_hold",   {28'b0, q_ben}, {28'b0, held.ben});
         chk("q_addr_hold",  q_addr, held.addr);
      end
      ao_m = s.ao; rt_m = s.rt; wb_data = s.wb; mem_rdata = s.rdata;
      fwd_rs = s.frs_sel; fwd_rt = s.frt_sel; instr_sb = s.sb; instr_sh = s.sh;
      instr_sw = s.sw; store_req = s.req; lrm_sel = s.lsel; reset = s.rst_n;
      #1;
      efrs  = s.frs_sel ? s.wb : s.ao;
      efrt  = s.frt_sel ? s.wb : s.rt;
      eaddr = efrs % 32'h2000_0000;
      model(efrs, efrt, s.sb, s.sh, s.sw, s.req, ewd, ebe, emis);
      chk("frs", frs, efrs);
      chk("frt", frt, efrt);
      chk("lrm", lrm, s.lsel ? s.rdata : efrt);
      chk("mem_addr", mem_addr, eaddr);
      chk("st_wdata", st_wdata, ewd);
      chk("st_ben", {28'b0, st_ben}, {28'b0, ebe});
      chk("st_misalign", {31'b0, st_misalign}, {31'b0, emis});
      nv = s.rst_n && s.req && (ebe != 4'b0000);
      if (!s.rst_n) held = '{32'h0, 4'h0, 32'h0};
      if (nv) begin
         held = '{ewd, ebe, eaddr};
         sb_q.push_back(held);
      end
      exp_v = nv;
   endtask

   function automatic stim_t mk(input logic [31:0] ao, input logic [31:0] rt,
                                input logic sb, input logic sh, input logic sw, input logic req);
      stim_t s;
      s = '{ao: ao, rt: rt, wb: 32'h0, rdata: 32'h0, frs_sel: 1'b0, frt_sel: 1'b0,
            sb: sb, sh: sh, sw: sw, req: req, lsel: 1'b0, rst_n: 1'b1};
      return s;
   endfunction

   initial begin
      stim_t s;
      reset = 1'b0;
      ao_m = '0; rt_m = '0; wb_data = '0; mem_rdata = '0;
      fwd_rs = 0; fwd_rt = 0; instr_sb = 0; instr_sh = 0; instr_sw = 0;
      store_req = 0; lrm_sel = 0;
      exp_v = 1'b0;
      held  = '{32'h0, 4'h0, 32'h0};

      s = mk(32'h0, 32'h0, 0, 0, 0, 0); s.rst_n = 1'b0;
      apply(s);
      apply(s);

      s = mk(32'h1000_0004, 32'hAABB_CCDD, 0, 0, 0, 0);
      s.wb = 32'h0000_0008; s.frs_sel = 1'b1;
      apply(s);
      s.lsel = 1'b1; s.rdata = 32'h1234_5678;
      apply(s);

      for (int a = 0; a < 4; a++) apply(mk(32'h100 + a, 32'hAABB_CCDD, 1, 0, 0, 1));
      apply(mk(32'h102, 32'hAABB_CCDD, 0, 1, 0, 1));
      apply(mk(32'h101, 32'hAABB_CCDD, 0, 1, 0, 1));
      apply(mk(32'h2000_0000, 32'h1122_3344, 0, 0, 1, 1));
      apply(mk(32'h2000_0002, 32'h1122_3344, 0, 0, 1, 1));
      apply(mk(32'h101, 32'hAABB_CCDD, 1, 1, 0, 1));
      apply(mk(32'h104, 32'h5555_6666, 0, 0, 1, 0));
      apply(mk(32'h0, 32'h0, 0, 0, 0, 1));

      apply(mk(32'h0000_0200, 32'hDEAD_BEEF, 0, 0, 1, 1));
      @(posedge clk);
      #2;
      chk("pre_reset_q_valid", {31'b0, q_valid}, 32'h1);
      chk("pre_reset_q_wdata", q_wdata, 32'hDEAD_BEEF);
      reset = 1'b0;
      #1;
      chk("async_reset_q_valid", {31'b0, q_valid}, 32'h0);
      chk("async_reset_q_wdata", q_wdata, 32'h0);
      chk("async_reset_q_ben",   {28'b0, q_ben}, 32'h0);
      chk("async_reset_q_addr",  q_addr, 32'h0);
      sb_q.delete();
      held  = '{32'h0, 4'h0, 32'h0};
      exp_v = 1'b0;
      s = mk(32'h0000_0300, 32'hCAFE_F00D, 0, 0, 1, 1); s.rst_n = 1'b0;
      apply(s);
      apply(s);
      apply(mk(32'h0000_0300, 32'hCAFE_F00D, 0, 0, 1, 1));

      for (int n = 0; n < 400; n++) begin
         s.ao      = $urandom;
         s.rt      = $urandom;
         s.wb      = $urandom;
         s.rdata   = $urandom;
         s.frs_sel = 1'($urandom_range(0, 1));
         s.frt_sel = 1'($urandom_range(0, 1));
         s.sb      = ($urandom_range(0, 3) == 0);
         s.sh      = ($urandom_range(0, 2) == 0);
         s.sw      = ($urandom_range(0, 1) == 0);
         s.req     = ($urandom_range(0, 3) != 0);
         s.lsel    = 1'($urandom_range(0, 1));
         s.rst_n   = 1'b1;
         apply(s);
      end

      apply(mk(32'h0, 32'h0, 0, 0, 0, 0));
      apply(mk(32'h0, 32'h0, 0, 0, 0, 0));
      chk("scoreboard_drained", sb_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
